aes256_cipher_iter: RTL and testbench
=====================================

# aes256_cipher_iter

Iterative AES-256 encryption core that directly consumes the 15-round-key bus produced by the key-expansion stage. It accepts one 128-bit plaintext block through a valid/ready handshake and runs the 14 AES-256 rounds at one round per clock. It then presents the 128-bit ciphertext through a valid/yumi handshake. It is the datapath stage between the key-expansion block and the chip's output FIFO.

## Interface
- `NR`, default 14: number of cipher rounds; fixed for AES-256.
- `clk_i` input, 1 bit: the single clock.
- `reset_i` input, 1 bit: **asynchronous, active-high** reset.
- `round_keys_i` input, 128*15 bits, indexed [0:1919]: round key i is bits [128*i : 128*i+127]; key 0 is the first 128 bits of the cipher key.
- `v_i` input, 1 bit: plaintext valid.
- `data_i` input, 128 bits, indexed [0:127]: plaintext.
- `ready_o` output, 1 bit: the core can accept a block.
- `v_o` output, 1 bit: ciphertext valid.
- `data_o` output, 128 bits, indexed [0:127]: ciphertext.
- `yumi_i` input, 1 bit: consumer takes the ciphertext. Legal only while `v_o`=1.

## Operation
- **Byte order:** byte n occupies bits [8n : 8n+7]. The state is column-major as in FIPS-197: byte n sits at row n%4, column n/4.
- **FSM states:** IDLE, RUN, DONE.
- **IDLE:**
  - `ready_o` = 1 (forced 0 while `reset_i` is high).
  - On `v_i & ready_o`: state_q <= `data_i` XOR rk[0], round_q <= 1, go to RUN.
- **RUN:**
  - For round_q = 1..13: state_q <= full round. This is SubBytes, ShiftRows, MixColumns, then XOR rk[round_q]. Increment round_q.
  - For round_q = 14: apply the final round, which omits MixColumns, XOR rk[14], then go to DONE.
- **DONE:**
  - `v_o` = 1 and `data_o` = state_q.
  - On `yumi_i`: go to IDLE, round_q <= 0.
- **No overlap:** `ready_o` = 0 in RUN and DONE. `v_i` in those states is ignored and does not affect the result.
- **Key stability:** `round_keys_i` must stay constant from the accept cycle through the last RUN cycle. The core does not latch keys; the upstream block guarantees stability.
- **Output hold:** `data_o` holds its value while `v_o`=1 and `yumi_i`=0, for any number of stall cycles.
- **Arithmetic:** MixColumns uses xtime (shift left, XOR 0x1B on carry-out) in GF(2^8). round_q is 4 bits and counts 0..14 only, never wraps.
- **Reset:**
  - Asserting `reset_i` in any state, including mid-RUN, immediately forces the reset values below. The in-flight block is discarded and never emitted.
  - Reset values: FSM IDLE, round_q 0, state_q 0, `v_o` 0, `data_o` 0, `ready_o` 0 while reset is high.
- **Illegal `yumi_i`:** `yumi_i` while `v_o`=0 is ignored.

## Timing
- **Accept:** at rising edge A (`v_i & ready_o` sampled high).
- **Rounds:** round k completes at edge A+k.
- **Output:** `v_o` rises after edge A+14, i.e. latency 14 cycles from accept to valid.
- **Release:** `yumi_i` sampled at edge Y gives `v_o`=0 and `ready_o`=1 after Y.
- **Throughput:** minimum accept-to-accept interval is 16 cycles when `yumi_i` is asserted in the first DONE cycle.
- **Output paths:** all outputs are registered or decoded from registered state only. There is no combinational path from `v_i`, `data_i` or `yumi_i` to any output.
- **Critical path:** one S-box, ShiftRows, MixColumns and XOR per cycle.

## Structure
- **Package `aes_pkg`:**
  - Constants: `AES_NR`=14, `AES_NK`=8, `AES_BLOCK_W`=128.
  - The FSM state enum.
  - The 256-entry S-box constant.
  - An xtime function, shared with the key-expansion stage.
- **Sub-module `aes_round`:**
  - Purely combinational.
  - Inputs: state_in[0:127], rk[0:127], final_i.
  - Output: state_out.
  - Instantiated once; round-key selection is a mux on round_q.
- Everything else lives in the top module: FSM, counter, state register.

## Test plan
- **FIPS-197 C.3 vector:**
  - Stimulus: round keys expanded from key 000102…1e1f, plaintext 00112233445566778899aabbccddeeff.
  - Response: `data_o`=8ea2b7ca516745bfeafc49904b496089, `v_o` high exactly 14 cycles after accept.
- **Backpressure:** hold `yumi_i`=0 for 20 cycles in DONE. `v_o` and `data_o` stay stable and `ready_o` stays 0 throughout. Then `yumi_i`=1 for one cycle, and `ready_o`=1 on the next cycle.
- **Busy-input ignore:** drive `v_i`=1 with random `data_i` every cycle during RUN and DONE. The C.3 ciphertext is unchanged, and exactly one block is accepted per IDLE window.
- **Reset mid-operation:** pulse `reset_i` asynchronously (not clock-aligned) at round 7. Outputs go to reset values immediately. `v_o` never rises for that block. The next C.3 block completes correctly.
- **Back-to-back:** apply an all-zero key with plaintext 0, then key 000102…1f with plaintext 00112233…eeff. Ciphertexts are dc95c078a2408989ad48a21492842087 and 8ea2b7ca516745bfeafc49904b496089, with 16-cycle spacing.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-256 constants, cipher FSM encoding, forward S-box and GF(2^8) helpers.
// Also imported by the key-expansion stage.
package aes_pkg;

   localparam int AES_NR      = 14;
   localparam int AES_NK      = 8;
   localparam int AES_BLOCK_W = 128;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } aes_fsm_e;

   // Entry x occupies bits [8x : 8x+7].
   localparam logic [0:2047] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX_TABLE[{x, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES encryption round: SubBytes, ShiftRows, MixColumns
// (skipped on the final round) and AddRoundKey.
module aes_round
   import aes_pkg::*;
(
   input  logic [0:AES_BLOCK_W-1] state_in,
   input  logic [0:AES_BLOCK_W-1] rk,
   input  logic                   final_i,
   output logic [0:AES_BLOCK_W-1] state_out
);

   logic [7:0] sub_b   [16];
   logic [7:0] shift_b [16];
   logic [7:0] mix_b   [16];

   for (genvar n = 0; n < 16; n++) begin : g_sub
      assign sub_b[n] = sbox(state_in[8*n +: 8]);
   end

   // Byte n is row n%4, column n/4; row r of column c comes from column (c+r)%4.
   for (genvar c = 0; c < 4; c++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
         assign shift_b[4*c + r] = sub_b[4*((c + r) % 4) + r];
      end

      assign mix_b[4*c + 0] = xtime(shift_b[4*c + 0]) ^ xtime(shift_b[4*c + 1]) ^ shift_b[4*c + 1]
                            ^ shift_b[4*c + 2] ^ shift_b[4*c + 3];
      assign mix_b[4*c + 1] = shift_b[4*c + 0] ^ xtime(shift_b[4*c + 1]) ^ xtime(shift_b[4*c + 2])
                            ^ shift_b[4*c + 2] ^ shift_b[4*c + 3];
      assign mix_b[4*c + 2] = shift_b[4*c + 0] ^ shift_b[4*c + 1] ^ xtime(shift_b[4*c + 2])
                            ^ xtime(shift_b[4*c + 3]) ^ shift_b[4*c + 3];
      assign mix_b[4*c + 3] = xtime(shift_b[4*c + 0]) ^ shift_b[4*c + 0] ^ shift_b[4*c + 1]
                            ^ shift_b[4*c + 2] ^ xtime(shift_b[4*c + 3]);
   end

   for (genvar n = 0; n < 16; n++) begin : g_key
      assign state_out[8*n +: 8] = (final_i ? shift_b[n] : mix_b[n]) ^ rk[8*n +: 8];
   end

endmodule

// File: rtl/aes256_cipher_iter.sv
// Iterative AES-256 encryptor: one round per clock, valid/ready in, valid/yumi out.
// Round keys come straight from the key-expansion bus and must stay stable while busy.
module aes256_cipher_iter
   import aes_pkg::*;
#(
   parameter int NR = AES_NR
) (
   input  logic                            clk_i,
   input  logic                            reset_i,
   input  logic [0:AES_BLOCK_W*(NR+1)-1]   round_keys_i,
   input  logic                            v_i,
   input  logic [0:AES_BLOCK_W-1]          data_i,
   output logic                            ready_o,
   output logic                            v_o,
   output logic [0:AES_BLOCK_W-1]          data_o,
   input  logic                            yumi_i
);

   localparam logic [3:0] LAST_ROUND = 4'(NR);

   aes_fsm_e               fsm_q;
   aes_fsm_e               fsm_d;
   logic [3:0]             round_q;
   logic [3:0]             round_d;
   logic [0:AES_BLOCK_W-1] state_q;
   logic [0:AES_BLOCK_W-1] state_d;
   logic [0:AES_BLOCK_W-1] round_key;
   logic [0:AES_BLOCK_W-1] round_out;
   logic                   last_round;

   assign last_round = (round_q == LAST_ROUND);
   assign round_key  = round_keys_i[{round_q, 7'b0000000} +: AES_BLOCK_W];

   aes_round u_round (
      .state_in  (state_q),
      .rk        (round_key),
      .final_i   (last_round),
      .state_out (round_out)
   );

   always_comb begin
      fsm_d   = fsm_q;
      round_d = round_q;
      state_d = state_q;
      case (fsm_q)
         ST_IDLE: begin
            if (v_i) begin
               state_d = data_i ^ round_keys_i[0:AES_BLOCK_W-1];
               round_d = 4'd1;
               fsm_d   = ST_RUN;
            end else begin
               fsm_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            state_d = round_out;
            if (last_round) begin
               fsm_d = ST_DONE;
            end else begin
               round_d = round_q + 4'd1;
            end
         end
         ST_DONE: begin
            if (yumi_i) begin
               fsm_d   = ST_IDLE;
               round_d = 4'd0;
            end else begin
               fsm_d = ST_DONE;
            end
         end
         default: begin
            fsm_d   = ST_IDLE;
            round_d = 4'd0;
            state_d = {AES_BLOCK_W{1'b0}};
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         fsm_q   <= ST_IDLE;
         round_q <= 4'd0;
         state_q <= {AES_BLOCK_W{1'b0}};
      end else begin
         fsm_q   <= fsm_d;
         round_q <= round_d;
         state_q <= state_d;
      end
   end

   // Outputs decode registered state only; ready is additionally masked by reset.
   assign ready_o = (fsm_q == ST_IDLE) & ~reset_i;
   assign v_o     = (fsm_q == ST_DONE);
   assign data_o  = v_o ? state_q : {AES_BLOCK_W{1'b0}};

endmodule

// File: tb/tb_aes256_cipher_iter.sv
// Bench for aes256_cipher_iter: a scoreboard queue filled from a byte-level AES-256
// model (S-box derived from the GF(2^8) inverse) and drained by an output monitor.
module tb_aes256_cipher_iter;

   localparam logic [0:255] KEY_C3  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [0:127] PT_C3   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [0:127] CT_C3   = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [0:127] CT_ZERO = 128'hdc95c078a2408989ad48a21492842087;

   logic          clk = 1'b0;
   logic          reset_i;
   logic [0:1919] round_keys_i;
   logic          v_i;
   logic [0:127]  data_i;
   logic          ready_o;
   logic          v_o;
   logic [0:127]  data_o;
   logic          yumi_i;

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   int n_out = 0;
   int n_expect_out = 0;

   logic [0:127] exp_q [$];
   int           exp_cyc_q [$];
   logic [7:0]   sbox_t [256];

   logic         prev_v = 1'b0;
   logic [0:127] prev_data = 128'h0;

   aes256_cipher_iter dut (
      .clk_i        (clk),
      .reset_i      (reset_i),
      .round_keys_i (round_keys_i),
      .v_i          (v_i),
      .data_i       (data_i),
      .ready_o      (ready_o),
      .v_o          (v_o),
      .data_o       (data_o),
      .yumi_i       (yumi_i)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] want);
      n_cmp++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, want);
      end
   endtask

   // Inputs change 1 ns after the falling edge; the monitor samples on the falling edge.
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // ---------------- reference model ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = 16'h0;
      for (int i = 0; i < 8; i++) if (b[i]) p = p ^ ({8'h00, a} << i);
      for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
      return p[7:0];
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
      return (b << k) | (b >> (8 - k));
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
   endfunction

   function automatic logic [0:1919] expand_key(input logic [0:255] key);
      logic [31:0]   w [60];
      logic [31:0]   t;
      logic [7:0]    rcon;
      logic [0:1919] rk;
      rcon = 8'h01;
      for (int i = 0; i < 8; i++) w[i] = key[32*i +: 32];
      for (int i = 8; i < 60; i++) begin
         t = w[i-1];
         if (i % 8 == 0) begin
            t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h000000};
            rcon = gmul(rcon, 8'h02);
         end else if (i % 8 == 4) begin
            t = sub_word(t);
         end
         w[i] = w[i-8] ^ t;
      end
      for (int i = 0; i < 60; i++) rk[32*i +: 32] = w[i];
      return rk;
   endfunction

   function automatic logic [0:127] encrypt(input logic [0:1919] rk, input logic [0:127] pt);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   col [4];
      logic [0:127] res;
      for (int n = 0; n < 16; n++) s[n] = pt[8*n +: 8] ^ rk[8*n +: 8];
      for (int r = 1; r <= 14; r++) begin
         for (int n = 0; n < 16; n++) t[n] = sbox_t[s[n]];
         for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++) s[row + 4*c] = t[row + 4*((c + row) % 4)];
         if (r < 14) begin
            for (int c = 0; c < 4; c++) begin
               for (int row = 0; row < 4; row++) col[row] = s[row + 4*c];
               for (int row = 0; row < 4; row++)
                  s[row + 4*c] = gmul(8'h02, col[row]) ^ gmul(8'h03, col[(row+1)%4])
                               ^ col[(row+2)%4] ^ col[(row+3)%4];
            end
         end
         for (int n = 0; n < 16; n++) s[n] = s[n] ^ rk[128*r + 8*n +: 8];
      end
      for (int n = 0; n < 16; n++) res[8*n +: 8] = s[n];
      return res;
   endfunction

   function automatic logic [0:127] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // ---------------- output monitor ----------------
   always @(negedge clk) begin
      if (v_o && !prev_v) begin
         if (exp_q.size() == 0) begin
            check("spurious_v_o", 128'd1, 128'd0);
         end else begin
            check("ciphertext", data_o, exp_q.pop_front());
            check("latency_cycle", 128'(cyc), 128'(exp_cyc_q.pop_front()));
            n_out++;
         end
      end
      if (prev_v && !reset_i) begin
         if (yumi_i) begin
            check("release_ready", 128'(ready_o), 128'd1);
            check("release_v", 128'(v_o), 128'd0);
         end else begin
            check("hold_v", 128'(v_o), 128'd1);
            check("hold_data", data_o, prev_data);
            check("hold_ready", 128'(ready_o), 128'd0);
         end
      end
      prev_v    = v_o;
      prev_data = data_o;
   end

   // ---------------- driver ----------------
   task automatic send(input logic [0:1919] rk, input logic [0:127] pt, input logic [0:127] ct,
                       input bit noise, input int stall, output int acc);
      int guard;
      bit any_ready;
      acc = -1;
      guard = 0;
      while (!ready_o && guard < 64) begin step(); guard++; end
      if (!ready_o) begin
         check("ready_timeout", 128'd0, 128'd1);
         return;
      end
      round_keys_i = rk;
      data_i = pt;
      v_i = 1'b1;
      acc = cyc + 1;
      exp_q.push_back(ct);
      exp_cyc_q.push_back(cyc + 15);
      n_expect_out++;
      step();
      v_i = noise;
      guard = 0;
      any_ready = 1'b0;
      while (!v_o && guard < 40) begin
         if (ready_o) any_ready = 1'b1;
         if (noise) data_i = rand128();
         step();
         guard++;
      end
      check("run_ready_low", 128'(any_ready), 128'd0);
      if (!v_o) begin
         check("valid_timeout", 128'd0, 128'd1);
         v_i = 1'b0;
         return;
      end
      for (int i = 0; i < stall; i++) begin
         if (noise) data_i = rand128();
         step();
      end
      yumi_i = 1'b1;
      step();
      yumi_i = 1'b0;
      v_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [0:1919] rk_c3;
      logic [0:1919] rk_zero;
      logic [0:1919] rk_r;
      logic [0:127]  pt_r;
      int            acc1;
      int            acc2;
      int            seen;

      reset_i = 1'b1;
      v_i = 1'b0;
      yumi_i = 1'b0;
      data_i = 128'h0;
      round_keys_i = 1920'h0;

      build_sbox();
      rk_c3   = expand_key(KEY_C3);
      rk_zero = expand_key(256'h0);

      #3;
      check("reset_ready", 128'(ready_o), 128'd0);
      check("reset_v", 128'(v_o), 128'd0);
      check("reset_data", data_o, 128'h0);
      step();
      step();
      reset_i = 1'b0;
      step();
      check("idle_ready", 128'(ready_o), 128'd1);

      // Plain vector, backpressure, then busy-input noise.
      send(rk_c3, PT_C3, CT_C3, 1'b0, 0, acc1);
      send(rk_c3, PT_C3, CT_C3, 1'b0, 20, acc1);
      send(rk_c3, PT_C3, CT_C3, 1'b1, 2, acc1);

      // Asynchronous reset in the middle of round 7.
      round_keys_i = rk_c3;
      data_i = PT_C3;
      v_i = 1'b1;
      step();
      v_i = 1'b0;
      repeat (6) step();
      #2 reset_i = 1'b1;
      #1;
      check("midreset_ready", 128'(ready_o), 128'd0);
      check("midreset_v", 128'(v_o), 128'd0);
      check("midreset_data", data_o, 128'h0);
      #2 reset_i = 1'b0;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (v_o) seen++;
      end
      check("no_emit_after_reset", 128'(seen), 128'd0);
      check("ready_after_reset", 128'(ready_o), 128'd1);
      send(rk_c3, PT_C3, CT_C3, 1'b0, 0, acc1);

      // Back-to-back with first-cycle yumi.
      send(rk_zero, 128'h0, CT_ZERO, 1'b0, 0, acc1);
      send(rk_c3, PT_C3, CT_C3, 1'b0, 0, acc2);
      check("b2b_spacing", 128'(acc2 - acc1), 128'd16);

      // Random keys and plaintexts against the model.
      for (int k = 0; k < 20; k++) begin
         rk_r = expand_key({$urandom, $urandom, $urandom, $urandom,
                            $urandom, $urandom, $urandom, $urandom});
         pt_r = rand128();
         send(rk_r, pt_r, encrypt(rk_r, pt_r), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 3)), acc1);
      end

      repeat (3) step();
      check("queue_empty", 128'(exp_q.size()), 128'd0);
      check("output_count", 128'(n_out), 128'(n_expect_out));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
